// File: rtl/la_dmux_pipe.sv
// rtl/la_dmux_pipe.sv - pipelined one-hot mux with select-integrity monitoring
// Valid travels with data; multi/none legality bits reach the error logic as the sample enters the output stage.
module la_dmux_pipe #(
  parameter int N      = 2,
  parameter int W      = 1,
  parameter int STAGES = 1,
  parameter int CW     = 8,
  parameter     PROP   = "DEFAULT"
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            clear,
  input  logic            valid_in,
  input  logic [N-1:0]    sel,
  input  logic [N*W-1:0]  in,
  output logic            valid_out,
  output logic [W-1:0]    out,
  output logic            err_multi,
  output logic            err_none,
  output logic [CW-1:0]   errcnt
);

  localparam logic [N-1:0]  SEL_ONE = N'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [W-1:0] d;
  logic         multi;
  logic         none;

  always_comb begin
    d = '0;
    for (int i = 0; i < N; i++) begin
      d = d | ({W{sel[i]}} & in[i*W +: W]);
    end
  end

  // Clearing the lowest set bit leaves something only when two or more bits were set.
  assign none  = ~|sel;
  assign multi = |(sel & (sel - SEL_ONE));

  logic [STAGES-1:0] sv;
  logic [W-1:0]      sd [STAGES];

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sv <= '0;
      for (int s = 0; s < STAGES; s++) begin
        sd[s] <= '0;
      end
    end else begin
      sv[0] <= valid_in;
      if (valid_in) begin
        sd[0] <= d;
      end
      for (int s = 1; s < STAGES; s++) begin
        sv[s] <= sv[s-1];
        if (sv[s-1]) begin
          sd[s] <= sd[s-1];
        end
      end
    end
  end

  assign valid_out = sv[STAGES-1];
  assign out       = sd[STAGES-1];

  // Legality bits of the sample about to enter the output stage.
  logic lv;
  logic lm;
  logic lz;

  generate
    if (STAGES == 1) begin : g_shallow
      assign lv = valid_in;
      assign lm = multi;
      assign lz = none;
    end else begin : g_deep
      logic [STAGES-2:0] pm;
      logic [STAGES-2:0] pz;

      always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
          pm <= '0;
          pz <= '0;
        end else begin
          pm[0] <= multi;
          pz[0] <= none;
          for (int s = 1; s < STAGES - 1; s++) begin
            pm[s] <= pm[s-1];
            pz[s] <= pz[s-1];
          end
        end
      end

      assign lv = sv[STAGES-2];
      assign lm = pm[STAGES-2];
      assign lz = pz[STAGES-2];
    end
  endgenerate

  logic em;
  logic ez;

  assign em = lv & lm;
  assign ez = lv & lz;

  // clear takes effect first, so an error arriving alongside it survives.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      err_multi <= 1'b0;
      err_none  <= 1'b0;
      errcnt    <= '0;
    end else if (clear) begin
      err_multi <= em;
      err_none  <= ez;
      errcnt    <= (em | ez) ? CNT_ONE : '0;
    end else begin
      if (em) err_multi <= 1'b1;
      if (ez) err_none  <= 1'b1;
      if ((em | ez) && errcnt != CNT_MAX) begin
        errcnt <= errcnt + CNT_ONE;
      end
    end
  end

endmodule
